ocr_multichannel_relay: RTL and testbench

Parametrised multi-channel overcurrent relay element on the 800 Hz processing clock. It takes one RMS current estimate per channel and runs an independent per-channel state machine for each. Each channel has an instantaneous high-set stage, a definite-time delayed stage with pickup/dropout hysteresis, and optional trip latching. It sits after the per-channel RMS estimation modules and replaces the single-channel instantaneous relay element as the source of the final trip signal.

---
 rtl/ocr_multichannel_relay.sv | 149 ++++++++++++++
 tb/tb_ocr_multichannel_relay.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ocr_multichannel_relay.sv
// Multi-channel overcurrent relay: per-channel instantaneous high-set stage plus
// definite-time delayed stage with pickup/dropout hysteresis and optional trip latching.
module ocr_multichannel_relay #(
  parameter int unsigned NCH        = 3,
  parameter int unsigned W          = 16,
  parameter int unsigned DELAY_W    = 12,
  parameter int unsigned HYST_SHIFT = 4
) (
  input  logic                 clk_800hz,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [NCH*W-1:0]     I_rms_bus,
  input  logic [W-1:0]         I_p,
  input  logic [W-1:0]         I_hs,
  input  logic [DELAY_W-1:0]   t_delay,
  input  logic                 latch_en,
  input  logic                 trip_clear,
  output logic [NCH-1:0]       pickup,
  output logic [NCH-1:0]       trip_ch,
  output logic [NCH-1:0]       trip_inst,
  output logic                 trip_signal
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PICKUP  = 2'd1,
    TRIPPED = 2'd2
  } state_t;

  state_t               state_q [NCH];
  state_t               state_d [NCH];
  logic [DELAY_W-1:0]   cnt_q   [NCH];
  logic [DELAY_W-1:0]   cnt_d   [NCH];
  logic [NCH-1:0]       inst_q;
  logic [NCH-1:0]       inst_d;
  logic [NCH-1:0]       trip_d;
  logic [W-1:0]         dropout;

  // I_p - (I_p >> k) is always <= I_p, so this cannot underflow.
  always_comb begin
    dropout = I_p - (I_p >> HYST_SHIFT);
  end

  // State register
  always_ff @(posedge clk_800hz or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
      end
      inst_q      <= '0;
      trip_signal <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      inst_q      <= inst_d;
      trip_signal <= |trip_d;
    end
  end

  // Next-state logic
  logic [W-1:0]       cur;
  logic               hs;
  logic               pu;
  logic               dout;
  logic [DELAY_W-1:0] cnt_inc;

  always_comb begin
    cur     = '0;
    hs      = 1'b0;
    pu      = 1'b0;
    dout    = 1'b0;
    cnt_inc = '0;
    inst_d  = inst_q;
    trip_d  = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      cur        = I_rms_bus[c*W +: W];
      hs         = (I_hs != '0) && (cur >= I_hs);
      pu         = cur >= I_p;
      dout       = cur < dropout;
      cnt_inc    = (cnt_q[c] == '1) ? cnt_q[c] : cnt_q[c] + 1'b1;

      if (trip_clear) begin
        state_d[c] = IDLE;
        cnt_d[c]   = '0;
        inst_d[c]  = 1'b0;
      end else if (sample_valid) begin
        unique case (state_q[c])
          IDLE: begin
            if (hs) begin
              state_d[c] = TRIPPED;
              inst_d[c]  = 1'b1;
            end else if (pu && (t_delay <= DELAY_W'(1))) begin
              state_d[c] = TRIPPED;
              inst_d[c]  = 1'b0;
            end else if (pu) begin
              state_d[c] = PICKUP;
              cnt_d[c]   = DELAY_W'(1);
            end
          end
          PICKUP: begin
            if (hs) begin
              state_d[c] = TRIPPED;
              inst_d[c]  = 1'b1;
            end else if (dout) begin
              state_d[c] = IDLE;
              cnt_d[c]   = '0;
            end else if (cnt_inc >= t_delay) begin
              state_d[c] = TRIPPED;
              cnt_d[c]   = cnt_inc;
              inst_d[c]  = 1'b0;
            end else begin
              cnt_d[c]   = cnt_inc;
            end
          end
          TRIPPED: begin
            if (!latch_en && dout) begin
              state_d[c] = IDLE;
              cnt_d[c]   = '0;
              inst_d[c]  = 1'b0;
            end else if (hs) begin
              inst_d[c]  = 1'b1;
            end
          end
          default: begin
            state_d[c] = IDLE;
            cnt_d[c]   = '0;
            inst_d[c]  = 1'b0;
          end
        endcase
      end
      trip_d[c] = (state_d[c] == TRIPPED);
    end
  end

  // Output decode of registered state
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      pickup[c]  = (state_q[c] == PICKUP);
      trip_ch[c] = (state_q[c] == TRIPPED);
    end
    trip_inst = inst_q;
  end

endmodule

// File: tb/tb_ocr_multichannel_relay.sv
// Scoreboard bench for ocr_multichannel_relay: hand-derived expected outputs are queued
// with each stimulus step and compared one cycle later.
module tb_ocr_multichannel_relay;

  localparam int unsigned NCH = 3;
  localparam int unsigned W   = 16;
  localparam int unsigned DW  = 12;

  logic              clk_800hz = 1'b0;
  logic              reset;
  logic              sample_valid;
  logic [NCH*W-1:0]  I_rms_bus;
  logic [W-1:0]      I_p;
  logic [W-1:0]      I_hs;
  logic [DW-1:0]     t_delay;
  logic              latch_en;
  logic              trip_clear;
  logic [NCH-1:0]    pickup;
  logic [NCH-1:0]    trip_ch;
  logic [NCH-1:0]    trip_inst;
  logic              trip_signal;

  ocr_multichannel_relay #(
    .NCH(NCH), .W(W), .DELAY_W(DW), .HYST_SHIFT(4)
  ) dut (
    .clk_800hz   (clk_800hz),
    .reset       (reset),
    .sample_valid(sample_valid),
    .I_rms_bus   (I_rms_bus),
    .I_p         (I_p),
    .I_hs        (I_hs),
    .t_delay     (t_delay),
    .latch_en    (latch_en),
    .trip_clear  (trip_clear),
    .pickup      (pickup),
    .trip_ch     (trip_ch),
    .trip_inst   (trip_inst),
    .trip_signal (trip_signal)
  );

  always #5 clk_800hz = ~clk_800hz;

  typedef struct {
    string      tag;
    logic [9:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [9:0] obs();
    return {pickup, trip_ch, trip_inst, trip_signal};
  endfunction

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {pu,tc,ti,ts}=%b, expected %b", tag, got, exp);
  endtask

  // One cycle of stimulus; expected outputs are visible just after the sampling edge.
  task automatic step(input string tag, input bit sv, input bit clr,
                      input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                      input logic [2:0] pu, input logic [2:0] tc, input logic [2:0] ti);
    exp_t e;
    @(negedge clk_800hz);
    sample_valid = sv;
    trip_clear   = clr;
    I_rms_bus    = {a2, a1, a0};
    sb.push_back('{tag, {pu, tc, ti, |tc}});
    @(posedge clk_800hz);
    #1;
    sample_valid = 1'b0;
    trip_clear   = 1'b0;
    if (sb.size() == 0) begin
      check({tag, "_empty"}, obs(), 10'h3ff);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs(), e.val);
    end
  endtask

  task automatic clear_all();
    step("clear", 1, 1, 0, 0, 0, 3'b000, 3'b000, 3'b000);
  endtask

  initial begin
    reset        = 1'b0;
    sample_valid = 1'b0;
    trip_clear   = 1'b0;
    I_rms_bus    = '0;
    I_p          = 16'd1000;
    I_hs         = 16'd4000;
    t_delay      = 12'd5;
    latch_en     = 1'b1;
    #2;
    check("reset_state", obs(), 10'b0);
    @(negedge clk_800hz);
    @(negedge clk_800hz);
    reset = 1'b1;

    // Delayed trip on ch0, with strobe-less cycles that must hold state
    step("dly_pu1", 1, 0, 1200, 0, 0, 3'b001, 3'b000, 3'b000);
    step("dly_pu2", 1, 0, 1200, 0, 0, 3'b001, 3'b000, 3'b000);
    step("nosv_hold1", 0, 0, 5000, 0, 0, 3'b001, 3'b000, 3'b000);
    step("nosv_hold2", 0, 0, 5000, 0, 0, 3'b001, 3'b000, 3'b000);
    step("dly_pu3", 1, 0, 1200, 0, 0, 3'b001, 3'b000, 3'b000);
    step("dly_pu4", 1, 0, 1200, 0, 0, 3'b001, 3'b000, 3'b000);
    step("dly_trip5", 1, 0, 1200, 0, 0, 3'b000, 3'b001, 3'b000);
    step("latch_hold", 1, 0, 0, 0, 0, 3'b000, 3'b001, 3'b000);
    step("clr_ignores_sample", 1, 1, 1200, 0, 0, 3'b000, 3'b000, 3'b000);
    step("repick_after_clr", 1, 0, 1200, 0, 0, 3'b001, 3'b000, 3'b000);
    clear_all();

    // Hysteresis band keeps the timer running
    step("hyst_a1", 1, 0, 0, 1200, 0, 3'b010, 3'b000, 3'b000);
    step("hyst_a2", 1, 0, 0, 1200, 0, 3'b010, 3'b000, 3'b000);
    step("hyst_a3", 1, 0, 0, 950,  0, 3'b010, 3'b000, 3'b000);
    step("hyst_a4", 1, 0, 0, 950,  0, 3'b010, 3'b000, 3'b000);
    step("hyst_a5_trip", 1, 0, 0, 1200, 0, 3'b000, 3'b010, 3'b000);
    clear_all();
    step("hyst_b1", 1, 0, 0, 1200, 0, 3'b010, 3'b000, 3'b000);
    step("hyst_b2", 1, 0, 0, 1200, 0, 3'b010, 3'b000, 3'b000);
    step("hyst_b3_drop", 1, 0, 0, 930, 0, 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++)
      step("hyst_b_repick", 1, 0, 0, 1200, 0, 3'b010, 3'b000, 3'b000);
    step("hyst_b_trip", 1, 0, 0, 1200, 0, 3'b000, 3'b010, 3'b000);
    clear_all();

    // Instantaneous stage
    step("inst_trip", 1, 0, 0, 0, 4000, 3'b000, 3'b100, 3'b100);
    clear_all();
    step("pu_then_hs1", 1, 0, 1200, 0, 0, 3'b001, 3'b000, 3'b000);
    step("pu_then_hs2", 1, 0, 4000, 0, 0, 3'b000, 3'b001, 3'b001);
    clear_all();
    I_hs = 16'd0;
    for (int i = 0; i < 4; i++)
      step("hs_off_pu", 1, 0, 0, 0, 65535, 3'b100, 3'b000, 3'b000);
    step("hs_off_trip", 1, 0, 0, 0, 65535, 3'b000, 3'b100, 3'b000);
    I_hs = 16'd4000;
    step("hs_after_dly_trip", 1, 0, 0, 0, 5000, 3'b000, 3'b100, 3'b100);
    clear_all();

    // Non-latching trip and dropout boundary (dropout = 938)
    latch_en = 1'b0;
    step("nolatch_trip", 1, 0, 4000, 0, 0, 3'b000, 3'b001, 3'b001);
    step("nolatch_938_hold", 1, 0, 938, 0, 0, 3'b000, 3'b001, 3'b001);
    step("nolatch_900_idle", 1, 0, 900, 0, 0, 3'b000, 3'b000, 3'b000);
    step("band_pu", 1, 0, 1200, 0, 0, 3'b001, 3'b000, 3'b000);
    step("band_937_drop", 1, 0, 937, 0, 0, 3'b000, 3'b000, 3'b000);
    latch_en = 1'b1;

    // Short delays and pickup boundary
    t_delay = 12'd0;
    step("tdelay0_trip", 1, 0, 1000, 0, 0, 3'b000, 3'b001, 3'b000);
    clear_all();
    t_delay = 12'd1;
    step("below_ip", 1, 0, 0, 999, 0, 3'b000, 3'b000, 3'b000);
    step("tdelay1_trip", 1, 0, 0, 1000, 0, 3'b000, 3'b010, 3'b000);
    clear_all();
    t_delay = 12'd5;

    // Lowering t_delay under a running timer
    for (int i = 0; i < 3; i++)
      step("lower_pu", 1, 0, 1200, 0, 0, 3'b001, 3'b000, 3'b000);
    t_delay = 12'd2;
    step("lower_trip", 1, 0, 1200, 0, 0, 3'b000, 3'b001, 3'b000);
    clear_all();
    t_delay = 12'd5;

    // Independence: ch1 trips while ch0 times
    step("ind1", 1, 0, 1200, 0,    0, 3'b001, 3'b000, 3'b000);
    step("ind2", 1, 0, 1200, 4000, 0, 3'b001, 3'b010, 3'b010);
    step("ind3", 1, 0, 1200, 0,    0, 3'b001, 3'b010, 3'b010);
    step("ind4", 1, 0, 1200, 0,    0, 3'b001, 3'b010, 3'b010);
    step("ind5", 1, 0, 1200, 0,    0, 3'b000, 3'b011, 3'b010);
    clear_all();

    // Asynchronous reset mid-timing
    for (int i = 0; i < 3; i++)
      step("pre_rst", 1, 0, 1200, 4000, 0, 3'b001, 3'b010, 3'b010);
    @(negedge clk_800hz);
    reset = 1'b0;
    #1;
    check("rst_async", obs(), 10'b0);
    @(posedge clk_800hz);
    #1;
    check("rst_held", obs(), 10'b0);
    @(negedge clk_800hz);
    reset = 1'b1;
    for (int i = 0; i < 4; i++)
      step("post_rst_pu", 1, 0, 1200, 0, 0, 3'b001, 3'b000, 3'b000);
    step("post_rst_trip", 1, 0, 1200, 0, 0, 3'b000, 3'b001, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
